// File: rtl/wbr_pkg.sv
// Shared definitions for the wrapper boundary register: output-mode encodings.
package wbr_pkg;

    typedef enum logic [1:0] {
        MODE_FUNC       = 2'b00,
        MODE_TEST       = 2'b01,
        MODE_SAFE       = 2'b10,
        MODE_SAFE_SHIFT = 2'b11
    } wbr_mode_e;

endpackage

// File: rtl/wbr_cell.sv
// One wrapper boundary cell: shift flop, update flop and the output mode mux.
import wbr_pkg::*;

module wbr_cell #(
    parameter logic SAFE_BIT = 1'b0
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      si,
    input  logic      cfi,
    input  logic      shift_en,
    input  logic      capture_en,
    input  logic      update_en,
    input  logic      shifting,
    input  wbr_mode_e mode,
    output logic      so,
    output logic      cfo
);

    logic sr;
    logic ur;

    // NOTE: non-blocking assignments let ur sample the pre-edge sr even while sr shifts.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sr <= 1'b0;
            ur <= SAFE_BIT;
        end else begin
            if (shift_en)
                sr <= si;
            else if (capture_en)
                sr <= cfi;
            if (update_en)
                ur <= sr;
        end
    end

    // NOTE: default assignment first keeps this mux free of inferred latches.
    always_comb begin
        cfo = ur;
        case (mode)
            MODE_FUNC:       cfo = cfi;
            MODE_TEST:       cfo = ur;
            MODE_SAFE:       cfo = SAFE_BIT;
            MODE_SAFE_SHIFT: cfo = shifting ? SAFE_BIT : ur;
            default:         cfo = ur;
        endcase
    end

    assign so = sr;

endmodule

// File: rtl/wbr_chain.sv
// WIDTH-cell IEEE 1500 wrapper boundary register with a saturating shift counter.
import wbr_pkg::*;

module wbr_chain #(
    parameter int              WIDTH      = 8,
    parameter logic [WIDTH-1:0] SAFE_VALUE = {WIDTH{1'b0}},
    parameter int              CW         = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             resetn,
    input  logic [WIDTH-1:0] CFI,
    output logic [WIDTH-1:0] CFO,
    input  logic             WSI,
    output logic             WSO,
    input  logic             SelectWR,
    input  logic             ShiftWR,
    input  logic             CaptureWR,
    input  logic             UpdateWR,
    input  logic [1:0]       Mode,
    output logic [CW-1:0]    ShiftCnt,
    output logic             ShiftFull
);

    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    logic             shift_en;
    logic             capture_en;
    logic             update_en;
    logic             cnt_clear;
    wbr_mode_e        mode;
    logic [WIDTH-1:0] sr_bits;
    logic [WIDTH-1:0] chain_in;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_nxt;
    logic             full_q;

    assign mode       = wbr_mode_e'(Mode);
    assign shift_en   = SelectWR & ShiftWR;
    assign capture_en = SelectWR & CaptureWR & ~ShiftWR;
    assign update_en  = SelectWR & UpdateWR;
    // Capture clears the counter even when shift wins the sr priority.
    assign cnt_clear  = SelectWR & (CaptureWR | UpdateWR);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        if (i == WIDTH - 1) begin : g_head
            assign chain_in[i] = WSI;
        end else begin : g_link
            assign chain_in[i] = sr_bits[i+1];
        end

        wbr_cell #(
            .SAFE_BIT (SAFE_VALUE[i])
        ) u_cell (
            .clk        (CLK),
            .resetn     (resetn),
            .si         (chain_in[i]),
            .cfi        (CFI[i]),
            .shift_en   (shift_en),
            .capture_en (capture_en),
            .update_en  (update_en),
            .shifting   (shift_en),
            .mode       (mode),
            .so         (sr_bits[i]),
            .cfo        (CFO[i])
        );
    end

    assign WSO = sr_bits[0];

    always_comb begin
        cnt_nxt = cnt_q;
        if (cnt_clear)
            cnt_nxt = '0;
        else if (shift_en && cnt_q != CNT_MAX)
            cnt_nxt = cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_nxt;
            full_q <= (cnt_nxt >= CNT_FULL);
        end
    end

    assign ShiftCnt  = cnt_q;
    assign ShiftFull = full_q;

endmodule

// File: tb/tb_wbr_chain.sv
// Directed bench for wbr_chain with a cycle-by-cycle behavioural reference.
module tb_wbr_chain;

    localparam int          WIDTH = 8;
    localparam int          CW    = 4;
    localparam logic [7:0]  SAFE  = 8'hA5;

    logic          CLK = 1'b0;
    logic          resetn;
    logic [7:0]    CFI;
    logic [7:0]    CFO;
    logic          WSI;
    logic          WSO;
    logic          SelectWR, ShiftWR, CaptureWR, UpdateWR;
    logic [1:0]    Mode;
    logic [CW-1:0] ShiftCnt;
    logic          ShiftFull;

    int checks   = 0;
    int failures = 0;

    wbr_chain #(
        .WIDTH      (WIDTH),
        .SAFE_VALUE (SAFE)
    ) dut (
        .CLK       (CLK),
        .resetn    (resetn),
        .CFI       (CFI),
        .CFO       (CFO),
        .WSI       (WSI),
        .WSO       (WSO),
        .SelectWR  (SelectWR),
        .ShiftWR   (ShiftWR),
        .CaptureWR (CaptureWR),
        .UpdateWR  (UpdateWR),
        .Mode      (Mode),
        .ShiftCnt  (ShiftCnt),
        .ShiftFull (ShiftFull)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: boundary register as a plain byte, counter as an integer.
    logic [7:0] m_sr, m_ur, m_old;
    int         m_cnt;

    always @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            m_sr  = 8'h00;
            m_ur  = SAFE;
            m_cnt = 0;
        end else if (SelectWR) begin
            m_old = m_sr;
            if (ShiftWR)
                m_sr = (m_sr >> 1) | (8'(WSI) << 7);
            else if (CaptureWR)
                m_sr = CFI;
            if (UpdateWR)
                m_ur = m_old;
            if (CaptureWR || UpdateWR)
                m_cnt = 0;
            else if (ShiftWR)
                m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
        end
    end

    function automatic logic [7:0] exp_cfo();
        case (Mode)
            2'b00:   return CFI;
            2'b01:   return m_ur;
            2'b10:   return SAFE;
            default: return (SelectWR && ShiftWR) ? SAFE : m_ur;
        endcase
    endfunction

    always @(negedge CLK) begin
        check("model_cfo", 64'(CFO), 64'(exp_cfo()));
        check("model_wso", 64'(WSO), 64'(m_sr[0]));
        check("model_cnt", 64'(ShiftCnt), 64'(m_cnt));
        check("model_full", 64'(ShiftFull), 64'(m_cnt >= WIDTH));
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ShiftWR = 1'b0; CaptureWR = 1'b0; UpdateWR = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] wso_seq;

        resetn = 1'b0; CFI = 8'h00; WSI = 1'b0; Mode = 2'b01;
        SelectWR = 1'b0; idle();
        #12;
        check("rst_cfo_test", 64'(CFO), 64'hA5);
        Mode = 2'b10; #1;
        check("rst_cfo_safe", 64'(CFO), 64'hA5);
        check("rst_wso", 64'(WSO), 64'h0);
        check("rst_cnt", 64'(ShiftCnt), 64'h0);
        check("rst_full", 64'(ShiftFull), 64'h0);
        #2 resetn = 1'b1;
        step();

        // Capture 3C, then shift it out LSB first.
        Mode = 2'b00; CFI = 8'h3C; SelectWR = 1'b1; CaptureWR = 1'b1;
        step();
        idle(); ShiftWR = 1'b1; WSI = 1'b0;
        wso_seq = 8'h00;
        for (int i = 0; i < 8; i++) begin
            wso_seq[i] = WSO;
            check("func_cfo", 64'(CFO), 64'h3C);
            step();
        end
        check("capture_wso_seq", 64'(wso_seq), 64'h3C);
        check("full_after_8", 64'(ShiftFull), 64'h1);
        check("cnt_after_8", 64'(ShiftCnt), 64'h8);

        // Shift in 5A, then update in TEST.
        pat = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            WSI = pat[i];
            step();
        end
        idle(); Mode = 2'b01; #1;
        check("test_cfo_pre_update", 64'(CFO), 64'hA5);
        UpdateWR = 1'b1;
        step();
        idle();
        check("test_cfo_updated", 64'(CFO), 64'h5A);
        check("update_clears_cnt", 64'(ShiftCnt), 64'h0);
        check("update_clears_full", 64'(ShiftFull), 64'h0);

        // SAFE_SHIFT: safe only while shifting.
        Mode = 2'b11; ShiftWR = 1'b1; WSI = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("safe_shift_during", 64'(CFO), 64'hA5);
            step();
        end
        idle(); #1;
        check("safe_shift_after", 64'(CFO), 64'h5A);

        // Update and shift on the same edge.
        CFI = 8'hFF; CaptureWR = 1'b1;
        step();
        idle(); UpdateWR = 1'b1; ShiftWR = 1'b1; WSI = 1'b0;
        step();
        idle(); Mode = 2'b01; #1;
        check("upd_shift_ur", 64'(CFO), 64'hFF);
        check("upd_shift_cnt", 64'(ShiftCnt), 64'h0);
        check("upd_shift_wso0", 64'(WSO), 64'h1);
        ShiftWR = 1'b1;
        for (int i = 0; i < 7; i++) step();
        check("upd_shift_sr_msb", 64'(WSO), 64'h0);
        check("upd_shift_cnt7", 64'(ShiftCnt), 64'h7);

        // Deselected: every enable ignored.
        SelectWR = 1'b0; ShiftWR = 1'b1; CaptureWR = 1'b1; UpdateWR = 1'b1;
        CFI = 8'h00; WSI = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("desel_cnt", 64'(ShiftCnt), 64'h7);
        check("desel_ur", 64'(CFO), 64'hFF);
        check("desel_wso", 64'(WSO), 64'h0);

        // Saturation over a long shift.
        SelectWR = 1'b1; idle(); ShiftWR = 1'b1;
        for (int i = 0; i < 300; i++) step();
        check("sat_cnt", 64'(ShiftCnt), 64'hF);
        check("sat_full", 64'(ShiftFull), 64'h1);

        // Reset in the middle of shifting ones.
        #2 resetn = 1'b0; #1;
        check("midrst_wso", 64'(WSO), 64'h0);
        check("midrst_cfo", 64'(CFO), 64'hA5);
        check("midrst_cnt", 64'(ShiftCnt), 64'h0);
        #3 resetn = 1'b1;
        step();
        check("post_rst_first_wso", 64'(WSO), 64'h0);
        check("post_rst_cnt", 64'(ShiftCnt), 64'h1);

        idle(); SelectWR = 1'b0;
        step(); step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wbr_chain.md
Name: wbr_chain

Overview:
Parametrised IEEE 1500 wrapper boundary register: WIDTH wrapper cells chained between WSI and WSO. Each cell has a shift stage and an update stage. Each cell also has a per-chain output mode: functional, test, safe, or safe-during-shift. It is the multi-bit, update-staged successor to the single-cell wrapper cell, and sits between core terminals and the wrapper boundary under WSC control. A shift counter reports when a full chain load has completed.

Parameters:
WIDTH, 8, number of wrapper cells (1..64)
SAFE_VALUE, {WIDTH{1'b0}}, value driven on CFO in safe modes; also the reset value of the update stage
CW, $clog2(WIDTH+1), shift-counter width (derived; do not override)

Ports:
CLK  input  1  wrapper clock; all state updates on rising edge
resetn  input  1  asynchronous active-low reset
CFI  input  WIDTH  functional inputs, one per cell
CFO  output  WIDTH  cell outputs toward core/boundary
WSI  input  1  wrapper serial input
WSO  output  1  wrapper serial output
SelectWR  input  1  chain selected by WIR
ShiftWR  input  1  shift enable
CaptureWR  input  1  capture enable
UpdateWR  input  1  update enable
Mode  input  2  00 FUNC, 01 TEST, 10 SAFE, 11 SAFE_SHIFT
ShiftCnt  output  CW  shift cycles since last capture/update
ShiftFull  output  1  high when ShiftCnt >= WIDTH

Behaviour:
- Reset (resetn=0, async):
  - shift stage sr = 0
  - update stage ur = SAFE_VALUE
  - ShiftCnt = 0, ShiftFull = 0
  - CFO follows Mode combinationally from the reset state
- SelectWR=0: sr, ur and ShiftCnt hold; ShiftWR, CaptureWR and UpdateWR are ignored.
- SelectWR=1, sr priority is ShiftWR > CaptureWR > hold:
  - shift: sr <= {WSI, sr[WIDTH-1:1]}. Cell WIDTH-1 is nearest WSI; WSO = sr[0] (combinational from the register).
  - capture: sr <= CFI.
- UpdateWR=1 with SelectWR=1:
  - ur <= sr, using the pre-edge sr.
  - Update is independent of shift/capture. Simultaneous update+shift loads ur with the old sr while sr shifts.
- CFO per Mode (combinational):
  - FUNC: CFO = CFI (transparent, zero latency)
  - TEST: CFO = ur
  - SAFE: CFO = SAFE_VALUE
  - SAFE_SHIFT: CFO = SAFE_VALUE while SelectWR&ShiftWR, else ur
  - A Mode change takes effect immediately; no state is altered.
- Latency:
  - a captured CFI appears at WSO after k further shifts for cell k
  - a shifted-in bit reaches cell WIDTH-1 after 1 shift and cell 0 after WIDTH shifts
  - updated data reaches CFO (TEST) the cycle after the UpdateWR edge
- ShiftCnt (SelectWR=1 only):
  - cleared to 0 on capture or update; clear wins over increment if simultaneous with shift
  - +1 per shift cycle, saturating at 2^CW-1 (no wrap)
- ShiftFull = (ShiftCnt >= WIDTH), registered with ShiftCnt.
- WIDTH=1: shift is sr <= WSI; WSO = sr.
- Reset mid-shift: chain state is lost immediately; the first WSO bit after release is 0.

Decomposition:
- Package wbr_pkg holds:
  - Mode encodings: MODE_FUNC, MODE_TEST, MODE_SAFE, MODE_SAFE_SHIFT
  - a 2-bit mode typedef
- Sub-module wbr_cell holds one sr flop, one ur flop and the CFO mux.
  - It takes cell-local safe bit, serial in, CFI bit and the decoded enables.
  - It is instantiated WIDTH times via generate.
- The counter, priority decode and WSO tap stay in wbr_chain.

Test Plan:
- Reset check, WIDTH=8, SAFE_VALUE=8'hA5: assert resetn=0 mid-operation → CFO=8'hA5 in TEST and SAFE, WSO=0, ShiftCnt=0, ShiftFull=0.
- Capture/shift-out: CFI=8'h3C, Mode=FUNC, CaptureWR for 1 cycle, then 8 ShiftWR cycles with WSI=0 → WSO sequence 0,0,1,1,1,1,0,0 (LSB first); CFO=CFI throughout; ShiftFull=1 after 8th shift.
- Shift-in/update: shift 8'h5A LSB-first (8 cycles), then UpdateWR with Mode=TEST → CFO=8'h5A from the next cycle; ShiftCnt cleared to 0.
- SAFE_SHIFT: ur=8'h5A, Mode=SAFE_SHIFT; shift 3 cycles → CFO=8'hA5 during shift, 8'h5A when ShiftWR drops.
- Simultaneous update+shift with sr=8'hFF, WSI=0 → ur=8'hFF, sr=8'h7F, ShiftCnt=0.
- Deselect and saturation: SelectWR=0 with all enables high → no state change. Then shift 300 cycles with WIDTH=8 (CW=4) → ShiftCnt saturates at 15 and ShiftFull stays 1.
